// File: rtl/adder_pkg.sv
// Shared definitions for the sequential chunk adder: FSM encoding, mode constant,
// and a constant-foldable ceiling log2 used for counter sizing.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_SUB = 1'b1;

    // Smallest r with 2**r >= v (0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational ripple-carry adder for one chunk.
// Ports:
//   a, b   : chunk operands
//   cin    : carry into bit 0
//   sum    : chunk sum
//   cout   : carry out of bit CHUNK-1
//   c_msb  : carry into bit CHUNK-1 (feeds signed-overflow detection)
module chunk_adder #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic carry;

    // Full-adder cells chained LSB to MSB.
    always_comb begin
        sum   = '0;
        c_msb = 1'b0;
        carry = cin;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (i == int'(CHUNK) - 1) begin
                c_msb = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor, CHUNK bits per clock, LSB chunk first.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready high only when idle)
//   a, b, cin, sub       : operands; sub=1 computes a-b and ignores cin
//   out_valid / out_ready: result handshake (out_valid high only when done)
//   sum, cout, ovf       : registered result, carry out, signed overflow
module seq_chunk_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCH   = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
    localparam int unsigned CNT_W = (NCH > 1) ? clog2(NCH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NCH - 1);

    if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
        $error("seq_chunk_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               carry_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q, ovf_q;
    logic               in_ready_q, out_valid_q;

    logic [CHUNK-1:0]   ch_sum;
    logic               ch_cout, ch_cmsb;
    logic [WIDTH-1:0]   a_nx, b_nx;
    logic               accept, last_run;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .cin   (carry_q),
        .sum   (ch_sum),
        .cout  (ch_cout),
        .c_msb (ch_cmsb)
    );

    // Operands shift right one chunk per cycle; finished sum chunks enter a_q from
    // the top, so after NCH cycles a_q holds the full result in place.
    if (NCH == 1) begin : g_one
        assign a_nx = ch_sum;
        assign b_nx = '0;
    end else begin : g_multi
        assign a_nx = {ch_sum, a_q[WIDTH-1:CHUNK]};
        assign b_nx = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
    end

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_run = (state_q == RUN) && (cnt_q == LAST);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
        end
    end

    // Operand capture and per-chunk datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= (sub == MODE_SUB) ? ~b : b;
            carry_q <= (sub == MODE_SUB) ? 1'b1 : cin;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            a_q     <= a_nx;
            b_q     <= b_nx;
            carry_q <= ch_cout;
            if (cnt_q != LAST) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Result registers load only on the RUN->DONE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (last_run) begin
            sum_q  <= a_nx;
            cout_q <= ch_cout;
            ovf_q  <= ch_cmsb ^ ch_cout;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
